// File: rtl/serial_link_vc_credit_sync_if.sv
// Link-side bundle for the virtual-channel credit block: per-channel source
// streams, the outgoing packet stage, received credit fields and local
// buffer-release pulses.
`timescale 1ns/1ps
interface serial_link_vc_credit_sync_if #(
  parameter int unsigned NumChannels = 2,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned CreditWidth = 4,
  parameter int unsigned ChIdWidth   = 1
);

  // Per-channel source streams
  logic [NumChannels*DataWidth-1:0] data_i;
  logic [NumChannels-1:0]           valid_i;
  logic [NumChannels-1:0]           ready_o;

  // Outgoing packet stage
  logic [DataWidth-1:0]             data_o;
  logic [ChIdWidth-1:0]             data_ch_o;
  logic [CreditWidth-1:0]           credits_o;
  logic [ChIdWidth-1:0]             cred_ch_o;
  logic                             credits_only_o;
  logic                             valid_o;
  logic                             ready_i;

  // Credits arriving from the peer
  logic                             rx_valid_i;
  logic [ChIdWidth-1:0]             rx_cred_ch_i;
  logic [CreditWidth-1:0]           rx_credits_i;

  // Local receive buffers releasing one element
  logic [NumChannels-1:0]           consumed_i;

  // The credit block itself
  modport slave (
    input  data_i, valid_i, ready_i, rx_valid_i, rx_cred_ch_i, rx_credits_i, consumed_i,
    output ready_o, data_o, data_ch_o, credits_o, cred_ch_o, credits_only_o, valid_o
  );

  // Whatever drives the sources and consumes the packets
  modport master (
    output data_i, valid_i, ready_i, rx_valid_i, rx_cred_ch_i, rx_credits_i, consumed_i,
    input  ready_o, data_o, data_ch_o, credits_o, cred_ch_o, credits_only_o, valid_o
  );

endinterface

// File: rtl/serial_link_vc_credit_sync.sv
// Credit-based flow control for several virtual channels sharing one serial
// link. Round-robin arbitration of the channel streams into a registered
// packet stage; every packet piggybacks the largest pending credit return,
// and a credits-only packet is forced when a return backlog builds up.
`timescale 1ns/1ps
module serial_link_vc_credit_sync #(
  parameter int unsigned NumChannels     = 2,
  parameter int unsigned DataWidth       = 32,
  parameter int unsigned NumCredits      = 8,
  parameter int unsigned ForceSendThresh = NumCredits - 4,
  parameter int unsigned CreditWidth     = $clog2(NumCredits + 1),
  parameter int unsigned ChIdWidth       = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input logic                         clk_i,
  input logic                         rst_ni,
  serial_link_vc_credit_sync_if.slave bus
);

  typedef logic [CreditWidth-1:0] cred_t;
  typedef logic [CreditWidth:0]   wide_t;   // one spare bit so overflow is visible
  typedef logic [ChIdWidth-1:0]   ch_t;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_e;

  // Registered state
  state_e               r_state;
  logic                 r_valid;
  logic [DataWidth-1:0] r_data;
  ch_t                  r_data_ch;
  cred_t                r_credits;
  ch_t                  r_cred_ch;
  logic                 r_credits_only;
  ch_t                  r_rr_ptr;
  cred_t                r_avail   [NumChannels];
  cred_t                r_to_send [NumChannels];

  // Combinational decisions for the current cycle
  ch_t                    w_cred_ch;
  cred_t                  w_snap;
  logic [NumChannels-1:0] w_eligible;
  ch_t                    w_pick;
  ch_t                    w_pick_hi;
  logic                   w_found_hi;
  ch_t                    w_ptr_nxt;
  logic [DataWidth-1:0]   w_pick_data;
  logic                   w_launch_ok;
  logic                   w_data_launch;
  logic                   w_force_launch;
  logic                   w_launch;
  logic [NumChannels-1:0] w_ready;
  wide_t                  w_avail_nxt   [NumChannels];
  wide_t                  w_to_send_nxt [NumChannels];

  // Credit channel: largest pending return, lowest index wins a tie.
  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_cred_ch = '0;
    w_snap    = r_to_send[0];
    for (int c = 1; c < NumChannels; c++) begin
      if (r_to_send[c] > w_snap) begin
        w_cred_ch = ch_t'(c);
        w_snap    = r_to_send[c];
      end
    end
  end

  // Eligibility: the last credit is only spent when it also carries returned credits.
  always_comb begin
    w_eligible = '0;
    for (int c = 0; c < NumChannels; c++) begin
      w_eligible[c] = bus.valid_i[c] &&
                      ((r_avail[c] > cred_t'(1)) ||
                       ((r_avail[c] == cred_t'(1)) && (w_snap != '0)));
    end
  end

  // Round-robin pick: first eligible at or above the pointer, else first eligible overall.
  always_comb begin
    w_pick     = '0;
    w_pick_hi  = '0;
    w_found_hi = 1'b0;
    for (int c = NumChannels - 1; c >= 0; c--) begin
      if (w_eligible[c]) begin
        w_pick = ch_t'(c);
        if (c >= int'(r_rr_ptr)) begin
          w_pick_hi  = ch_t'(c);
          w_found_hi = 1'b1;
        end
      end
    end
    if (w_found_hi) begin
      w_pick = w_pick_hi;
    end
  end

  assign w_ptr_nxt   = (int'(w_pick) == int'(NumChannels) - 1) ? '0 : w_pick + 1'b1;
  assign w_pick_data = bus.data_i[int'(w_pick)*DataWidth +: DataWidth];

  // A new packet may load when the stage is empty or is being emptied this cycle.
  assign w_launch_ok    = (r_state == ST_IDLE) || bus.ready_i;
  assign w_data_launch  = w_launch_ok && (|w_eligible);
  assign w_force_launch = w_launch_ok && !(|w_eligible) && (w_snap >= cred_t'(ForceSendThresh));
  assign w_launch       = w_data_launch || w_force_launch;

  // Accept strobe back to the chosen source, only in the launch cycle.
  always_comb begin
    w_ready = '0;
    if (w_data_launch) begin
      w_ready[w_pick] = 1'b1;
    end
  end

  // Next counter values: received credits, launch spend, consumed pulses and committed returns all combine.
  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      w_avail_nxt[c]   = {1'b0, r_avail[c]};
      w_to_send_nxt[c] = {1'b0, r_to_send[c]} + wide_t'(bus.consumed_i[c]);
      if (bus.rx_valid_i && (int'(bus.rx_cred_ch_i) == c)) begin
        w_avail_nxt[c] = w_avail_nxt[c] + {1'b0, bus.rx_credits_i};
      end
      if (w_data_launch && (int'(w_pick) == c)) begin
        w_avail_nxt[c] = w_avail_nxt[c] - wide_t'(1);
      end
      if (w_launch && (int'(w_cred_ch) == c)) begin
        w_to_send_nxt[c] = w_to_send_nxt[c] - {1'b0, w_snap};
      end
    end
  end

  // Credit counters per channel.
  // NOTE: these small counter arrays are live protocol state, so each entry is reset, unlike a data RAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumChannels; c++) begin
        r_avail[c]   <= cred_t'(NumCredits);
        r_to_send[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        r_avail[c]   <= w_avail_nxt[c][CreditWidth-1:0];
        r_to_send[c] <= w_to_send_nxt[c][CreditWidth-1:0];
      end
    end
  end

  // Output stage FSM: load a packet on launch, hold it unchanged until the link takes it.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= ST_IDLE;
      r_valid        <= 1'b0;
      r_data         <= '0;
      r_data_ch      <= '0;
      r_credits      <= '0;
      r_cred_ch      <= '0;
      r_credits_only <= 1'b0;
      r_rr_ptr       <= '0;
    end else if (w_launch) begin
      r_state        <= ST_HOLD;
      r_valid        <= 1'b1;
      r_data         <= w_data_launch ? w_pick_data : '0;
      r_data_ch      <= w_data_launch ? w_pick : '0;
      r_credits      <= w_snap;
      r_cred_ch      <= w_cred_ch;
      r_credits_only <= !w_data_launch;
      if (w_data_launch) begin
        r_rr_ptr <= w_ptr_nxt;
      end
    end else if ((r_state == ST_HOLD) && bus.ready_i) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
    end
  end

  assign bus.ready_o        = w_ready;
  assign bus.valid_o        = r_valid;
  assign bus.data_o         = r_data;
  assign bus.data_ch_o      = r_data_ch;
  assign bus.credits_o      = r_credits;
  assign bus.cred_ch_o      = r_cred_ch;
  assign bus.credits_only_o = r_credits_only;

`ifndef SYNTHESIS
  // Protocol errors from the surroundings: counter overflow or an unknown credit channel.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      if (bus.rx_valid_i) begin
        assert (32'(bus.rx_cred_ch_i) < NumChannels);
      end
      for (int c = 0; c < NumChannels; c++) begin
        assert (w_avail_nxt[c] <= wide_t'(NumCredits));
        assert (w_to_send_nxt[c] <= wide_t'(NumCredits));
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_link_vc_credit_sync.sv
// Directed bench for serial_link_vc_credit_sync: stimulus pushes hand-computed
// packets into a scoreboard queue, a negedge monitor pops and compares every
// packet the link accepts.
`timescale 1ns/1ps
module tb_serial_link_vc_credit_sync;

  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int CHW = 1;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [CHW-1:0] data_ch;
    logic [CW-1:0]  credits;
    logic [CHW-1:0] cred_ch;
    logic           only;
  } pkt_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_link_vc_credit_sync_if #(
    .NumChannels(NCH), .DataWidth(DW), .CreditWidth(CW), .ChIdWidth(CHW)
  ) bus ();

  serial_link_vc_credit_sync #(
    .NumChannels(NCH), .DataWidth(DW), .NumCredits(8), .ForceSendThresh(4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pkts   = 0;
  pkt_t        sb_q[$];
  pkt_t        mon_exp;
  pkt_t        hold_exp;
  bit          hold_chk = 1'b0;
  int          src_left [NCH];
  int          src_idx  [NCH];
  logic [31:0] src_base [NCH];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [31:0] d, input logic dch, input logic [3:0] cr,
                              input logic cch, input logic only);
    pkt_t p;
    p.data    = d;
    p.data_ch = dch;
    p.credits = cr;
    p.cred_ch = cch;
    p.only    = only;
    return p;
  endfunction

  function automatic pkt_t cur_pkt();
    return mk(bus.data_o, bus.data_ch_o, bus.credits_o, bus.cred_ch_o, bus.credits_only_o);
  endfunction

  // Monitor: packets accepted by the link, hold stability and one-hot accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ready_o != '0) begin
        check("ready_onehot", 64'($onehot(bus.ready_o)), 64'(1));
      end
      if (hold_chk) begin
        check("hold_stable", 64'(cur_pkt()), 64'(hold_exp));
        check("hold_valid", 64'(bus.valid_o), 64'(1));
        check("hold_no_accept", 64'(bus.ready_o), 64'(0));
      end
      if (bus.valid_o && bus.ready_i) begin
        check("sb_has_expected", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) begin
          mon_exp = sb_q.pop_front();
          check($sformatf("pkt%0d", n_pkts), 64'(cur_pkt()), 64'(mon_exp));
        end
        n_pkts++;
      end
    end
  end

  task automatic drive_src();
    for (int c = 0; c < NCH; c++) begin
      bus.valid_i[c]          = (src_left[c] != 0);
      bus.data_i[c*DW +: DW]  = src_base[c] + 32'(src_idx[c]);
    end
  endtask

  // One clock: note accepts at negedge, advance sources just after posedge.
  task automatic step();
    logic [NCH-1:0] acc;
    @(negedge clk);
    acc = bus.ready_o & bus.valid_i;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (acc[c]) begin
        src_left[c]--;
        src_idx[c]++;
      end
    end
    drive_src();
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.ready_i      = 1'b1;
    bus.rx_valid_i   = 1'b0;
    bus.rx_cred_ch_i = '0;
    bus.rx_credits_i = '0;
    bus.consumed_i   = '0;
    hold_chk         = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      src_left[c] = 0;
      src_idx[c]  = 0;
    end
    drive_src();
    @(negedge clk);
    check("rst_valid", 64'(bus.valid_o), 64'(0));
    check("rst_outputs", 64'(cur_pkt()), 64'(0));
    check("rst_ready", 64'(bus.ready_o), 64'(0));
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    src_base[0] = 32'hA000_0000;
    src_base[1] = 32'hB000_0000;
    do_reset();

    // Ch0 streams 10 beats: 7 packets, then the last credit is held back.
    src_left[0] = 10;
    drive_src();
    for (int i = 0; i < 7; i++) sb_q.push_back(mk(32'hA000_0000 + 32'(i), 1'b0, 4'd0, 1'b0, 1'b0));
    repeat (12) step();
    check("t1_all_pkts", 64'(sb_q.size()), 64'(0));
    check("t1_valid_idle", 64'(bus.valid_o), 64'(0));
    check("t1_ch0_blocked", 64'(bus.ready_o), 64'(0));

    // One consumed pulse on ch1 lets the last credit go, carrying that return.
    sb_q.push_back(mk(32'hA000_0007, 1'b0, 4'd1, 1'b1, 1'b0));
    bus.consumed_i = 2'b10;
    step();
    bus.consumed_i = 2'b00;
    repeat (5) step();
    check("t2_last_credit_pkt", 64'(sb_q.size()), 64'(0));
    check("t2_ch0_empty", 64'(bus.ready_o), 64'(0));

    // Peer returns 3 credits to ch0: two more beats go out (avail 3 -> 1).
    sb_q.push_back(mk(32'hA000_0008, 1'b0, 4'd0, 1'b0, 1'b0));
    sb_q.push_back(mk(32'hA000_0009, 1'b0, 4'd0, 1'b0, 1'b0));
    bus.rx_valid_i   = 1'b1;
    bus.rx_cred_ch_i = 1'b0;
    bus.rx_credits_i = 4'd3;
    step();
    bus.rx_valid_i   = 1'b0;
    bus.rx_credits_i = 4'd0;
    repeat (5) step();
    check("t2b_rx_credit_pkts", 64'(sb_q.size()), 64'(0));

    // Both channels busy: alternate 0,1,... at one packet per cycle.
    do_reset();
    src_left[0] = 6;
    src_left[1] = 6;
    drive_src();
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(mk(32'hA000_0000 + 32'(i), 1'b0, 4'd0, 1'b0, 1'b0));
      sb_q.push_back(mk(32'hB000_0000 + 32'(i), 1'b1, 4'd0, 1'b0, 1'b0));
    end
    repeat (13) step();
    check("t3_full_rate", 64'(sb_q.size()), 64'(0));
    repeat (2) step();
    check("t3_drained", 64'(bus.valid_o), 64'(0));

    // No data, four ch1 consumed pulses: one credits-only packet.
    do_reset();
    sb_q.push_back(mk(32'h0, 1'b0, 4'd4, 1'b1, 1'b1));
    for (int i = 0; i < 4; i++) begin
      bus.consumed_i = 2'b10;
      step();
    end
    bus.consumed_i = 2'b00;
    repeat (6) step();
    check("t4_credit_only_pkt", 64'(sb_q.size()), 64'(0));
    check("t4_no_repeat", 64'(bus.valid_o), 64'(0));

    // Held packet with ready_i low; returns during the hold ride the next packet.
    do_reset();
    bus.ready_i = 1'b0;
    src_left[0] = 2;
    drive_src();
    sb_q.push_back(mk(32'hA000_0000, 1'b0, 4'd0, 1'b0, 1'b0));
    sb_q.push_back(mk(32'hA000_0001, 1'b0, 4'd5, 1'b1, 1'b0));
    step();
    hold_exp = mk(32'hA000_0000, 1'b0, 4'd0, 1'b0, 1'b0);
    hold_chk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.consumed_i = 2'b10;
      step();
    end
    bus.consumed_i = 2'b00;
    hold_chk       = 1'b0;
    bus.ready_i    = 1'b1;
    repeat (4) step();
    check("t5_hold_release", 64'(sb_q.size()), 64'(0));

    // Reset in the middle of a hold drops the packet and restores all counters.
    do_reset();
    bus.ready_i = 1'b0;
    src_left[0] = 1;
    drive_src();
    step();
    hold_exp = mk(32'hA000_0000, 1'b0, 4'd0, 1'b0, 1'b0);
    hold_chk = 1'b1;
    bus.consumed_i = 2'b10;
    repeat (2) step();
    bus.consumed_i = 2'b00;
    hold_chk = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid_drop", 64'(bus.valid_o), 64'(0));
    do_reset();
    src_left[0] = 10;
    drive_src();
    for (int i = 0; i < 7; i++) sb_q.push_back(mk(32'hA000_0000 + 32'(i), 1'b0, 4'd0, 1'b0, 1'b0));
    repeat (12) step();
    check("t6_counters_restored", 64'(sb_q.size()), 64'(0));
    check("t6_ch0_blocked", 64'(bus.ready_o), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
